// File: rtl/piso_tx_pkg.sv
// -----------------------------------------------------------------------------
// piso_tx_pkg
// Shared types for the serial-transmit controller: FSM state encodings and a
// counter-width helper.
// Configuration macro: PISO_TX_PARITY_EN (the PAR state is only reachable
// when it is defined; the encoding is reserved either way).
// -----------------------------------------------------------------------------
package piso_tx_pkg;

  localparam logic [1:0] ST_IDLE_ENC  = 2'd0;
  localparam logic [1:0] ST_SHIFT_ENC = 2'd1;
  localparam logic [1:0] ST_PAR_ENC   = 2'd2;
  localparam logic [1:0] ST_GAP_ENC   = 2'd3;

  typedef enum logic [1:0] {
    IDLE  = ST_IDLE_ENC,
    SHIFT = ST_SHIFT_ENC,
    PAR   = ST_PAR_ENC,
    GAP   = ST_GAP_ENC
  } piso_state_t;

  // Bits needed to hold values 0..n-1, never less than one bit.
  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/piso_shift_reg.sv
// -----------------------------------------------------------------------------
// piso_shift_reg
// WIDTH-bit parallel-load / left-shift register with zero fill.
// Ports:
//   clk    rising-edge clock
//   rst_n  synchronous active-low reset (clears the register)
//   load   capture din (has priority over shift)
//   shift  shift left by one, 0 enters at the LSB
//   din    parallel load value
//   msb    current most significant bit
// -----------------------------------------------------------------------------
module piso_shift_reg
  import piso_tx_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic             shift,
  input  logic [WIDTH-1:0] din,
  output logic             msb
);

  logic [WIDTH-1:0] sreg;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sreg <= '0;
    end else if (load) begin
      sreg <= din;
    end else if (shift) begin
      sreg <= {sreg[WIDTH-2:0], 1'b0};
    end
  end

  assign msb = sreg[WIDTH-1];

endmodule

// File: rtl/piso_tx_ctrl.sv
// -----------------------------------------------------------------------------
// piso_tx_ctrl
// Serial-transmit controller. Accepts a parallel word on a valid/ready
// handshake, shifts it out MSB-first one bit per clock with frame_start /
// frame_last strobes, then holds the line idle for GAP_CYCLES cycles.
// Optional macro PISO_TX_PARITY_EN appends an even-parity bit to each frame.
// Parameters:
//   WIDTH       data word width (>= 2)
//   GAP_CYCLES  idle cycles forced after each frame (0 allowed)
// Ports:
//   clk          rising-edge clock
//   rst_n        synchronous active-low reset
//   in_data      parallel word to transmit
//   in_valid     producer has a word on in_data
//   in_ready     controller can accept a word (IDLE only)
//   ser_out      serial data bit (0 whenever ser_valid is 0)
//   ser_valid    ser_out carries a frame bit
//   frame_start  first bit of a frame
//   frame_last   final bit of a frame
//   busy         controller is not in IDLE
//   done         one-cycle pulse on the cycle after frame_last
// -----------------------------------------------------------------------------
module piso_tx_ctrl
  import piso_tx_pkg::*;
#(
  parameter int WIDTH      = 4,
  parameter int GAP_CYCLES = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_valid,
  output logic             in_ready,
  output logic             ser_out,
  output logic             ser_valid,
  output logic             frame_start,
  output logic             frame_last,
  output logic             busy,
  output logic             done
);

  localparam int CNT_W = cnt_width(WIDTH);
  localparam int GAP_W = cnt_width(GAP_CYCLES + 1);

  piso_state_t      state, next_state;
  logic [CNT_W-1:0] bit_cnt, bit_cnt_n;
  logic [GAP_W-1:0] gap_cnt, gap_cnt_n;

  logic             accept;
  logic             sr_msb;
  logic             sr_shift;
  logic [WIDTH-1:0] sr_din;

  logic             ser_out_n;
  logic             ser_valid_n;
  logic             frame_start_n;
  logic             frame_last_n;

`ifdef PISO_TX_PARITY_EN
  logic             parity_q;
`endif

  assign accept = (state == IDLE) && in_valid && in_ready;

  // Outputs are registered, so the MSB goes straight to ser_out on the accept
  // edge and the shift register keeps only the bits still to be sent. Its msb
  // is therefore always the bit for the following cycle.
  assign sr_din   = {in_data[WIDTH-2:0], 1'b0};
  assign sr_shift = (state == SHIFT);

  piso_shift_reg #(
    .WIDTH (WIDTH)
  ) u_shift (
    .clk   (clk),
    .rst_n (rst_n),
    .load  (accept),
    .shift (sr_shift),
    .din   (sr_din),
    .msb   (sr_msb)
  );

  // State, counters and registered outputs.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= IDLE;
      bit_cnt     <= '0;
      gap_cnt     <= '0;
      in_ready    <= 1'b1;
      ser_out     <= 1'b0;
      ser_valid   <= 1'b0;
      frame_start <= 1'b0;
      frame_last  <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
`ifdef PISO_TX_PARITY_EN
      parity_q    <= 1'b0;
`endif
    end else begin
      state       <= next_state;
      bit_cnt     <= bit_cnt_n;
      gap_cnt     <= gap_cnt_n;
      in_ready    <= (next_state == IDLE);
      ser_out     <= ser_out_n;
      ser_valid   <= ser_valid_n;
      frame_start <= frame_start_n;
      frame_last  <= frame_last_n;
      busy        <= (next_state != IDLE);
      done        <= frame_last;
`ifdef PISO_TX_PARITY_EN
      if (accept) begin
        parity_q <= ^in_data;
      end
`endif
    end
  end

  // Next-state and counter logic. Counters are reloaded on state entry and
  // parked at zero on exit, so they never wrap.
  always_comb begin
    next_state = state;
    bit_cnt_n  = bit_cnt;
    gap_cnt_n  = gap_cnt;
    case (state)
      IDLE: begin
        if (accept) begin
          next_state = SHIFT;
          bit_cnt_n  = CNT_W'(WIDTH - 1);
        end
      end
      SHIFT: begin
        if (bit_cnt == '0) begin
`ifdef PISO_TX_PARITY_EN
          next_state = PAR;
`else
          if (GAP_CYCLES > 0) begin
            next_state = GAP;
            gap_cnt_n  = GAP_W'(GAP_CYCLES - 1);
          end else begin
            next_state = IDLE;
          end
`endif
        end else begin
          bit_cnt_n = bit_cnt - CNT_W'(1);
        end
      end
`ifdef PISO_TX_PARITY_EN
      PAR: begin
        if (GAP_CYCLES > 0) begin
          next_state = GAP;
          gap_cnt_n  = GAP_W'(GAP_CYCLES - 1);
        end else begin
          next_state = IDLE;
        end
      end
`endif
      GAP: begin
        if (gap_cnt == '0) begin
          next_state = IDLE;
        end else begin
          gap_cnt_n = gap_cnt - GAP_W'(1);
        end
      end
      default: begin
        next_state = IDLE;
      end
    endcase
  end

  // Output values for the coming cycle, decoded from the next state.
  always_comb begin
    ser_out_n     = 1'b0;
    ser_valid_n   = 1'b0;
    frame_start_n = 1'b0;
    frame_last_n  = 1'b0;
    if (next_state == SHIFT) begin
      ser_valid_n   = 1'b1;
      ser_out_n     = accept ? in_data[WIDTH-1] : sr_msb;
      frame_start_n = accept;
`ifndef PISO_TX_PARITY_EN
      frame_last_n  = (bit_cnt_n == '0);
`endif
    end
`ifdef PISO_TX_PARITY_EN
    else if (next_state == PAR) begin
      ser_valid_n  = 1'b1;
      ser_out_n    = parity_q;
      frame_last_n = 1'b1;
    end
`endif
  end

endmodule

// File: tb/tb_piso_tx_ctrl.sv
// -----------------------------------------------------------------------------
// tb_piso_tx_ctrl
// Bench for piso_tx_ctrl: one instance with GAP_CYCLES=1 (scoreboarded serial
// stream) and one with GAP_CYCLES=0. Follows PISO_TX_PARITY_EN when defined.
// -----------------------------------------------------------------------------
module tb_piso_tx_ctrl;

  localparam int W = 4;
`ifdef PISO_TX_PARITY_EN
  localparam int P = 1;
`else
  localparam int P = 0;
`endif
  localparam int L = W + P;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;

  logic [W-1:0] in_data = '0;
  logic         in_valid = 1'b0;
  logic         in_ready, ser_out, ser_valid, frame_start, frame_last, busy, done;

  logic [W-1:0] in_data0 = '0;
  logic         in_valid0 = 1'b0;
  logic         in_ready0, ser_out0, ser_valid0, frame_start0, frame_last0, busy0, done0;

  int           vectors = 0;
  int           miscompares = 0;
  logic [2:0]   exp_q[$];
  logic [2:0]   mon_e;

  always #5 clk = ~clk;

  piso_tx_ctrl #(.WIDTH(W), .GAP_CYCLES(1)) dut (
    .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_valid(in_valid),
    .in_ready(in_ready), .ser_out(ser_out), .ser_valid(ser_valid),
    .frame_start(frame_start), .frame_last(frame_last), .busy(busy), .done(done)
  );

  piso_tx_ctrl #(.WIDTH(W), .GAP_CYCLES(0)) dut0 (
    .clk(clk), .rst_n(rst_n), .in_data(in_data0), .in_valid(in_valid0),
    .in_ready(in_ready0), .ser_out(ser_out0), .ser_valid(ser_valid0),
    .frame_start(frame_start0), .frame_last(frame_last0), .busy(busy0), .done(done0)
  );

  // Expected k-th frame bit (k = 1..L) of word w.
  function automatic logic exp_bit(input logic [W-1:0] w, input int k);
    if (k <= W) return w[W-k];
    return ^w;
  endfunction

  // Queue the expected {ser_out, frame_start, frame_last} for every frame bit.
  function automatic void push_word(input logic [W-1:0] w);
    for (int i = W - 1; i >= 0; i--)
      exp_q.push_back({w[i], (i == W - 1), (i == 0) && (P == 0)});
    if (P == 1)
      exp_q.push_back({^w, 1'b0, 1'b1});
  endfunction

  task automatic tick();
    @(negedge clk);
  endtask

  // Scoreboard: every frame bit on the GAP_CYCLES=1 instance is popped and compared.
  always @(negedge clk) begin
    if (ser_valid === 1'b1) begin
      vectors++;
      if (exp_q.size() == 0) begin
        miscompares++;
        $display("[TB] FAIL unexpected_bit got ser_out=%b with empty scoreboard", ser_out);
      end else begin
        mon_e = exp_q.pop_front();
        if ({ser_out, frame_start, frame_last} !== mon_e) begin
          miscompares++;
          $display("[TB] FAIL serial_bit got {out,start,last}=%b want %b", {ser_out, frame_start, frame_last}, mon_e);
        end
      end
    end else begin
      vectors++;
      if (ser_valid !== 1'b0 || ser_out !== 1'b0 || frame_start !== 1'b0 || frame_last !== 1'b0) begin
        miscompares++;
        $display("[TB] FAIL idle_line got {valid,out,start,last}=%b want 0000", {ser_valid, ser_out, frame_start, frame_last});
      end
    end
  end

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) tick();
    vectors++;
    if ({in_ready, ser_out, ser_valid, frame_start, frame_last, busy, done} !== 7'b1000000) begin
      miscompares++;
      $display("[TB] FAIL reset_outputs got %b want 1000000", {in_ready, ser_out, ser_valid, frame_start, frame_last, busy, done});
    end
    vectors++;
    if ({in_ready0, ser_out0, ser_valid0, frame_start0, frame_last0, busy0, done0} !== 7'b1000000) begin
      miscompares++;
      $display("[TB] FAIL reset_outputs_gap0 got %b want 1000000", {in_ready0, ser_out0, ser_valid0, frame_start0, frame_last0, busy0, done0});
    end
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_idle();
    for (int c = 0; c < 20; c++) begin
      tick();
      vectors++;
      if ({ser_valid, busy, done, in_ready} !== 4'b0001) begin
        miscompares++;
        $display("[TB] FAIL idle_hold cycle %0d got {valid,busy,done,ready}=%b want 0001", c, {ser_valid, busy, done, in_ready});
      end
    end
  endtask

  task automatic test_basic();
    tick();
    vectors++;
    if (in_ready !== 1'b1) begin
      miscompares++;
      $display("[TB] FAIL basic_ready got %b want 1", in_ready);
    end
    in_data  = 4'b1011;
    in_valid = 1'b1;
    push_word(4'b1011);
    for (int c = 1; c <= L + 3; c++) begin
      tick();
      if (c == 1) in_valid = 1'b0;
      vectors++;
      if ({ser_valid, busy, done, in_ready} !== {(c <= L), (c <= L + 1), (c == L + 1), (c >= L + 2)}) begin
        miscompares++;
        $display("[TB] FAIL basic_timing cycle %0d got {valid,busy,done,ready}=%b want %b", c,
                 {ser_valid, busy, done, in_ready}, {(c <= L), (c <= L + 1), (c == L + 1), (c >= L + 2)});
      end
    end
  endtask

  task automatic test_back_to_back();
    tick();
    in_data  = 4'b1100;
    in_valid = 1'b1;
    push_word(4'b1100);
    for (int c = 1; c <= L + 1; c++) begin
      tick();
      in_data = 4'b0011;
      vectors++;
      if (in_ready !== 1'b0) begin
        miscompares++;
        $display("[TB] FAIL b2b_ready_busy cycle %0d got %b want 0", c, in_ready);
      end
      if (c == L + 1) begin
        vectors++;
        if (ser_valid !== 1'b0) begin
          miscompares++;
          $display("[TB] FAIL b2b_gap_valid got %b want 0", ser_valid);
        end
      end
    end
    tick();
    vectors++;
    if (in_ready !== 1'b1) begin
      miscompares++;
      $display("[TB] FAIL b2b_second_accept got in_ready=%b want 1", in_ready);
    end
    push_word(4'b0011);
    tick();
    in_valid = 1'b0;
    vectors++;
    if ({ser_valid, frame_start} !== 2'b11) begin
      miscompares++;
      $display("[TB] FAIL b2b_second_start got {valid,start}=%b want 11", {ser_valid, frame_start});
    end
    for (int c = L + 4; c <= 2 * L + 4; c++) tick();
    vectors++;
    if ({in_ready, busy} !== 2'b10) begin
      miscompares++;
      $display("[TB] FAIL b2b_drain got {ready,busy}=%b want 10", {in_ready, busy});
    end
  endtask

  task automatic test_gap0();
    logic [W-1:0] w1, w2;
    w1 = 4'b1001;
    w2 = 4'b0110;
    tick();
    in_data0  = w1;
    in_valid0 = 1'b1;
    for (int c = 1; c <= L; c++) begin
      tick();
      in_valid0 = 1'b0;
      vectors++;
      if ({ser_valid0, ser_out0, frame_start0, in_ready0} !== {1'b1, exp_bit(w1, c), (c == 1), 1'b0}) begin
        miscompares++;
        $display("[TB] FAIL gap0_frame1 bit %0d got {valid,out,start,ready}=%b want %b", c,
                 {ser_valid0, ser_out0, frame_start0, in_ready0}, {1'b1, exp_bit(w1, c), (c == 1), 1'b0});
      end
    end
    tick();
    vectors++;
    if ({done0, in_ready0, busy0, ser_valid0} !== 4'b1100) begin
      miscompares++;
      $display("[TB] FAIL gap0_done got {done,ready,busy,valid}=%b want 1100", {done0, in_ready0, busy0, ser_valid0});
    end
    in_data0  = w2;
    in_valid0 = 1'b1;
    for (int c = 1; c <= L; c++) begin
      tick();
      in_valid0 = 1'b0;
      vectors++;
      if ({ser_valid0, ser_out0, frame_start0, done0} !== {1'b1, exp_bit(w2, c), (c == 1), 1'b0}) begin
        miscompares++;
        $display("[TB] FAIL gap0_frame2 bit %0d got {valid,out,start,done}=%b want %b", c,
                 {ser_valid0, ser_out0, frame_start0, done0}, {1'b1, exp_bit(w2, c), (c == 1), 1'b0});
      end
    end
    tick();
    vectors++;
    if ({done0, in_ready0} !== 2'b11) begin
      miscompares++;
      $display("[TB] FAIL gap0_done2 got {done,ready}=%b want 11", {done0, in_ready0});
    end
    tick();
  endtask

  task automatic test_reset_mid();
    tick();
    in_data  = 4'b1111;
    in_valid = 1'b1;
    push_word(4'b1111);
    tick();
    in_valid = 1'b0;
    tick();
    rst_n = 1'b0;
    tick();
    exp_q.delete();
    vectors++;
    if ({in_ready, ser_out, ser_valid, frame_start, frame_last, busy, done} !== 7'b1000000) begin
      miscompares++;
      $display("[TB] FAIL midreset_outputs got %b want 1000000", {in_ready, ser_out, ser_valid, frame_start, frame_last, busy, done});
    end
    rst_n = 1'b1;
    for (int c = 0; c < 5; c++) begin
      tick();
      vectors++;
      if ({done, in_ready, ser_valid} !== 3'b010) begin
        miscompares++;
        $display("[TB] FAIL midreset_quiet cycle %0d got {done,ready,valid}=%b want 010", c, {done, in_ready, ser_valid});
      end
    end
    in_data  = 4'b0101;
    in_valid = 1'b1;
    push_word(4'b0101);
    for (int c = 1; c <= L + 2; c++) begin
      tick();
      in_valid = 1'b0;
      vectors++;
      if (done !== (c == L + 1)) begin
        miscompares++;
        $display("[TB] FAIL midreset_done cycle %0d got %b want %b", c, done, (c == L + 1));
      end
    end
  endtask

  task automatic test_parity();
    tick();
    in_data  = 4'b0111;
    in_valid = 1'b1;
    push_word(4'b0111);
    for (int c = 1; c <= L + 2; c++) begin
      tick();
      in_valid = 1'b0;
      if (c == W) begin
        vectors++;
        if (frame_last !== (P == 0)) begin
          miscompares++;
          $display("[TB] FAIL parity_lastdata got frame_last=%b want %b", frame_last, (P == 0));
        end
      end
      if (c == L) begin
        vectors++;
        if ({ser_out, ser_valid, frame_last} !== 3'b111) begin
          miscompares++;
          $display("[TB] FAIL parity_bit got {out,valid,last}=%b want 111", {ser_out, ser_valid, frame_last});
        end
      end
    end
  endtask

  initial begin
    $display("[TB] start, parity bits per frame = %0d", P);
    test_reset();
    test_idle();
    test_basic();
    test_back_to_back();
    test_gap0();
    test_reset_mid();
    test_parity();
    repeat (3) tick();
    vectors++;
    if (exp_q.size() != 0) begin
      miscompares++;
      $display("[TB] FAIL scoreboard_drain got %0d pending bits want 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
